// File: rtl/sys_mem_responder.sv
// Responder side of the memory request/response handshake: 16 KB word array,
// fixed-latency access, four-phase response and a sticky illegal-request flag.
module sys_mem_responder #(
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 16,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_cs,
   input  logic              i_read_req,
   input  logic              i_write_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_datatomem,
   output logic [DATA_W-1:0] o_datafrommem,
   output logic              o_mem_resp,
   output logic              o_busy,
   output logic              o_err
);

   // state  | meaning
   // S_IDLE | waiting for a qualified request
   // S_BUSY | access accepted, latency counter running
   // S_RESP | mem_resp high until both request lines are withdrawn
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam int         DEPTH  = 2 ** (ADDR_W - 1);
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic              r_op_wr;
   logic [ADDR_W-2:0] r_idx;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_resp;
   logic              r_err;

   logic w_rd_v;
   logic w_wr_v;
   logic w_ill;
   logic w_abort;
   logic w_done;
   logic w_commit;
   logic w_unused_addr_lsb;

   assign w_rd_v = i_cs & i_read_req & ~i_write_req;
   assign w_wr_v = i_cs & i_write_req & ~i_read_req;
   assign w_ill  = i_cs & i_read_req & i_write_req;

   // Withdrawal of the original request or of cs wins over completion.
   assign w_abort  = ~i_cs | (r_op_wr ? ~i_write_req : ~i_read_req);
   assign w_done   = (r_state == S_BUSY) & ~w_abort & (r_cnt == 4'd0);
   assign w_commit = w_done & r_op_wr & reset_n;

   assign w_unused_addr_lsb = i_addr[0];

   // The array has no reset so its contents survive reset_n.
   always_ff @(posedge clk) begin
      if (w_commit)
         r_mem[r_idx] <= r_wdata;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_op_wr <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_resp  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_rd_v || w_wr_v) begin
                  r_op_wr <= w_wr_v;
                  r_idx   <= i_addr[ADDR_W-1:1];
                  r_wdata <= i_datatomem;
                  r_cnt   <= LAT_M1;
                  r_state <= S_BUSY;
               end else if (w_ill) begin
                  r_err <= 1'b1;
               end
            end
            S_BUSY: begin
               if (w_abort) begin
                  r_cnt   <= 4'd0;
                  r_state <= S_IDLE;
               end else if (r_cnt == 4'd0) begin
                  r_resp  <= 1'b1;
                  r_state <= S_RESP;
                  if (!r_op_wr)
                     r_rdata <= r_mem[r_idx];
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (!i_read_req && !i_write_req) begin
                  r_resp  <= 1'b0;
                  r_rdata <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_datafrommem = r_rdata;
   assign o_mem_resp    = r_resp;
   assign o_busy        = (r_state != S_IDLE);
   assign o_err         = r_err;

endmodule

// File: tb/tb_sys_mem_responder.sv
// Directed bench for sys_mem_responder: latency, aliasing, illegal requests,
// aborts, held responses and cs gating with hand-computed expectations.
module tb_sys_mem_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cs;
   logic        read_req;
   logic        write_req;
   logic [13:0] addr;
   logic [15:0] datatomem;
   logic [15:0] datafrommem;
   logic        mem_resp;
   logic        busy;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sys_mem_responder #(.ADDR_W(14), .DATA_W(16), .LATENCY(4)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_cs          (cs),
      .i_read_req    (read_req),
      .i_write_req   (write_req),
      .i_addr        (addr),
      .i_datatomem   (datatomem),
      .o_datafrommem (datafrommem),
      .o_mem_resp    (mem_resp),
      .o_busy        (busy),
      .o_err         (err)
   );

   // All helpers start and end positioned just after a negedge.
   task automatic start_req(input bit wr, input logic [13:0] a, input logic [15:0] d);
      cs        = 1'b1;
      read_req  = ~wr;
      write_req = wr;
      addr      = a;
      datatomem = d;
   endtask

   task automatic wait_resp(output int lat);
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (mem_resp === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic release_req();
      cs        = 1'b0;
      read_req  = 1'b0;
      write_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_xact(input bit wr, input logic [13:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] rd);
      start_req(wr, a, d);
      wait_resp(lat);
      rd = datafrommem;
      release_req();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({mem_resp, busy, err} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got resp/busy/err=%b want 000", {mem_resp, busy, err});
      end
      n_checks++;
      if (datafrommem !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_data: got %h want 0000", datafrommem);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      int          lat;
      logic [15:0] rd;
      start_req(1'b1, 14'h0010, 16'hBEEF);
      wait_resp(lat);
      n_checks++;
      if (lat !== 4) begin
         n_fail++;
         $display("FAIL wr_latency: got %0d edges want 4", lat);
      end
      n_checks++;
      if ({busy, datafrommem} !== {1'b1, 16'h0000}) begin
         n_fail++;
         $display("FAIL wr_resp_state: got busy=%b data=%h want busy=1 data=0000", busy, datafrommem);
      end
      release_req();
      n_checks++;
      if ({mem_resp, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL wr_release: got resp/busy=%b want 00", {mem_resp, busy});
      end
      do_xact(1'b0, 14'h0010, 16'h0000, lat, rd);
      n_checks++;
      if (lat !== 4) begin
         n_fail++;
         $display("FAIL rd_latency: got %0d edges want 4", lat);
      end
      n_checks++;
      if (rd !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL rd_data: got %h want beef", rd);
      end
   endtask

   task automatic test_alias();
      int          lat;
      logic [15:0] rd;
      do_xact(1'b1, 14'h0021, 16'h1234, lat, rd);
      do_xact(1'b0, 14'h0020, 16'h0000, lat, rd);
      n_checks++;
      if (rd !== 16'h1234) begin
         n_fail++;
         $display("FAIL alias_low: got %h want 1234", rd);
      end
      do_xact(1'b1, 14'h3FFE, 16'hFFFF, lat, rd);
      do_xact(1'b0, 14'h3FFF, 16'h0000, lat, rd);
      n_checks++;
      if (rd !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL alias_top: got %h want ffff", rd);
      end
      do_xact(1'b0, 14'h0000, 16'h0000, lat, rd);
      do_xact(1'b0, 14'h0010, 16'h0000, lat, rd);
      n_checks++;
      if (rd !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL alias_no_wrap: got %h want beef", rd);
      end
   endtask

   task automatic test_illegal();
      int          lat;
      logic [15:0] rd;
      cs        = 1'b1;
      read_req  = 1'b1;
      write_req = 1'b1;
      addr      = 14'h0010;
      datatomem = 16'h0BAD;
      repeat (6) @(negedge clk);
      n_checks++;
      if ({err, mem_resp, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL ill_flags: got err/resp/busy=%b want 100", {err, mem_resp, busy});
      end
      release_req();
      repeat (3) @(negedge clk);
      do_xact(1'b0, 14'h0010, 16'h0000, lat, rd);
      n_checks++;
      if ({err, rd} !== {1'b1, 16'hBEEF}) begin
         n_fail++;
         $display("FAIL ill_sticky: got err=%b data=%h want err=1 data=beef", err, rd);
      end
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL ill_reset_clear: got err=%b want 0", err);
      end
   endtask

   task automatic test_abort();
      int          lat;
      logic [15:0] rd;
      int          resp_seen;
      start_req(1'b1, 14'h0010, 16'h5555);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      write_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy, mem_resp} !== 2'b00) begin
         n_fail++;
         $display("FAIL abort_wr_state: got busy/resp=%b want 00", {busy, mem_resp});
      end
      cs = 1'b0;
      resp_seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (mem_resp !== 1'b0) resp_seen++;
      end
      n_checks++;
      if (resp_seen !== 0) begin
         n_fail++;
         $display("FAIL abort_wr_noresp: got %0d resp cycles want 0", resp_seen);
      end
      do_xact(1'b0, 14'h0010, 16'h0000, lat, rd);
      n_checks++;
      if (rd !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL abort_wr_data: got %h want beef", rd);
      end
      // cs withdrawn during a read
      start_req(1'b0, 14'h0010, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      cs = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy, mem_resp} !== 2'b00) begin
         n_fail++;
         $display("FAIL abort_cs_state: got busy/resp=%b want 00", {busy, mem_resp});
      end
      read_req = 1'b0;
      // reset during BUSY
      start_req(1'b1, 14'h0010, 16'h5555);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({mem_resp, busy, err, datafrommem} !== {3'b000, 16'h0000}) begin
         n_fail++;
         $display("FAIL abort_rst_outputs: got resp/busy/err=%b data=%h want 000 0000",
                  {mem_resp, busy, err}, datafrommem);
      end
      repeat (4) @(negedge clk);
      write_req = 1'b0;
      cs        = 1'b0;
      reset_n   = 1'b1;
      @(negedge clk);
      do_xact(1'b0, 14'h0010, 16'h0000, lat, rd);
      n_checks++;
      if (rd !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL abort_rst_data: got %h want beef", rd);
      end
   endtask

   task automatic test_held_resp();
      int          lat;
      logic [15:0] rd;
      // write data/address changed right after acceptance must be ignored
      start_req(1'b1, 14'h0200, 16'h1111);
      @(posedge clk);
      @(negedge clk);
      addr      = 14'h0300;
      datatomem = 16'h2222;
      wait_resp(lat);
      n_checks++;
      if (lat !== 3) begin
         n_fail++;
         $display("FAIL latch_wr_latency: got %0d edges want 3", lat);
      end
      release_req();
      do_xact(1'b0, 14'h0200, 16'h0000, lat, rd);
      n_checks++;
      if (rd !== 16'h1111) begin
         n_fail++;
         $display("FAIL latch_wr_data: got %h want 1111", rd);
      end
      do_xact(1'b1, 14'h0100, 16'hA5A5, lat, rd);
      start_req(1'b0, 14'h0100, 16'h0000);
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         addr      = 14'h0400 + 14'(i * 2);
         datatomem = 16'(i);
         if (mem_resp === 1'b1) begin
            lat = i;
            break;
         end
      end
      n_checks++;
      if (lat !== 4) begin
         n_fail++;
         $display("FAIL held_latency: got %0d edges want 4", lat);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         addr      = 14'h0200 + 14'(i * 2);
         datatomem = 16'hF000 + 16'(i);
         n_checks++;
         if ({mem_resp, datafrommem} !== {1'b1, 16'hA5A5}) begin
            n_fail++;
            $display("FAIL held_cycle%0d: got resp=%b data=%h want resp=1 data=a5a5",
                     i, mem_resp, datafrommem);
         end
      end
      read_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({mem_resp, datafrommem} !== {1'b0, 16'h0000}) begin
         n_fail++;
         $display("FAIL held_drop: got resp=%b data=%h want resp=0 data=0000", mem_resp, datafrommem);
      end
      cs = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_cs_gating();
      int          lat;
      logic [15:0] rd;
      int          active;
      cs        = 1'b0;
      write_req = 1'b1;
      addr      = 14'h0010;
      datatomem = 16'h7777;
      active    = 0;
      repeat (8) begin
         @(negedge clk);
         if ({mem_resp, busy} !== 2'b00) active++;
      end
      write_req = 1'b0;
      read_req  = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if ({mem_resp, busy} !== 2'b00) active++;
      end
      read_req = 1'b0;
      n_checks++;
      if (active !== 0) begin
         n_fail++;
         $display("FAIL cs_gate_idle: got %0d active cycles want 0", active);
      end
      do_xact(1'b0, 14'h0010, 16'h0000, lat, rd);
      n_checks++;
      if (rd !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL cs_gate_data: got %h want beef", rd);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      start_req(1'b0, 14'h0020, 16'h0000);
      wait_resp(lat);
      read_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({mem_resp, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL b2b_gap: got resp/busy=%b want 00", {mem_resp, busy});
      end
      start_req(1'b0, 14'h3FFE, 16'h0000);
      wait_resp(lat);
      n_checks++;
      if ({lat, datafrommem} !== {32'd4, 16'hFFFF}) begin
         n_fail++;
         $display("FAIL b2b_second: got lat=%0d data=%h want lat=4 data=ffff", lat, datafrommem);
      end
      release_req();
   endtask

   initial begin
      reset_n   = 1'b0;
      cs        = 1'b0;
      read_req  = 1'b0;
      write_req = 1'b0;
      addr      = '0;
      datatomem = '0;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_alias();
      test_illegal();
      test_abort();
      test_held_resp();
      test_cs_gating();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded 200000 time units");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sys_mem_responder.md
Name: sys_mem_responder

Overview:
- Responder end of the memory interface request/response protocol; it models the 16 KByte system memory (MSS) that services the memory interface unit.
- Accepts level-held read/write requests qualified by chip select.
- Performs the access after a fixed latency and raises mem_resp, holding it until the initiator withdraws its request (four-phase handshake).
- Synthesizable single-port array plus control FSM; sits between the memory interface unit and the top level.

Parameters:
ADDR_W, 14, byte address width; memory size is 2**ADDR_W bytes = 16 KB.
DATA_W, 16, data word width; memory holds 2**(ADDR_W-1) words of DATA_W bits.
LATENCY, 4, cycles from request acceptance to mem_resp assertion; legal range 1..15.

Ports:
clk  in  1  clock; all logic on posedge.
reset_n  in  1  synchronous, active-low reset.
cs  in  1  chip select; a request is valid only when cs=1.
read_req  in  1  level read request from initiator.
write_req  in  1  level write request from initiator.
addr  in  ADDR_W  byte address; word index = addr[ADDR_W-1:1]; addr[0] is ignored.
datatomem  in  DATA_W  write data.
datafrommem  out  DATA_W  read data; valid only while mem_resp=1 for a read.
mem_resp  out  1  response; held high until the request is withdrawn.
busy  out  1  high in any state other than IDLE.
err  out  1  sticky illegal-request flag; cleared only by reset.

Behaviour:
- Reset (reset_n=0 at posedge):
  - mem_resp=0, datafrommem=0, busy=0, err=0, state=IDLE, latency counter=0.
  - Array contents are not cleared.
  - Reset mid-transaction aborts the transaction; a pending write is not committed.
- Request qualifiers:
  - rd_v = cs & read_req & ~write_req
  - wr_v = cs & write_req & ~read_req
  - ill = cs & read_req & write_req
- IDLE:
  - rd_v or wr_v at posedge N: latch op, addr word index and datatomem; counter=LATENCY-1; go to BUSY.
  - ill: set err=1 and stay in IDLE; no access and no response.
  - Request inputs while cs=0 are ignored.
- BUSY:
  - Decrement the counter each posedge.
  - At the posedge where counter=0 (posedge N+LATENCY), go to RESP and set mem_resp=1.
    - Read: datafrommem <= mem[latched index].
    - Write: mem[latched index] <= latched data, and datafrommem stays 0.
  - Abort: if the original request bit (read_req for a read, write_req for a write) or cs is sampled low at any posedge in BUSY:
    - go to IDLE with no array update and mem_resp stays 0;
    - this takes priority over completion at the same edge.
  - addr/datatomem changes after acceptance are ignored; latched values are used.
- RESP:
  - mem_resp=1 and datafrommem held stable.
  - When both read_req=0 and write_req=0 are sampled at a posedge: mem_resp<=0, datafrommem<=0, go to IDLE.
  - A new request is accepted no earlier than the following posedge, so there is at least one idle cycle between transactions.
  - If the request stays high indefinitely, mem_resp stays high; there is no timeout.
- Ordering: a read of an address written by the immediately preceding transaction returns the new data (the write is committed before RESP).
- Only one outstanding transaction; requests arriving in BUSY/RESP are not queued.
- Width rules: full-word accesses only; no byte enables. Byte selection is the initiator's responsibility.
- busy = (state != IDLE).

Test Plan:
- Write then read, LATENCY=4:
  - wr_v with addr=0x0010, data=0xBEEF held at posedge 0 -> mem_resp high after posedge 4; drop write_req -> mem_resp low after the next posedge.
  - Then rd_v addr=0x0010 -> mem_resp high 4 edges after acceptance with datafrommem=0xBEEF.
- Address aliasing: write 0x1234 to addr=0x0021, read addr=0x0020 -> 0x1234; write 0xFFFF to addr=0x3FFE, read addr=0x3FFF -> 0xFFFF (top word, no wrap error).
- Illegal request: cs=1 with read_req=write_req=1 -> err=1 persists, mem_resp stays 0, array unchanged (read back 0xBEEF at 0x0010); only reset_n=0 clears err.
- Abort:
  - write_req dropped 2 edges into BUSY with addr=0x0010, data=0x5555 -> no mem_resp, busy falls, subsequent read returns 0xBEEF.
  - Reset asserted during BUSY -> same result, all outputs 0.
- Held response and latched inputs: after acceptance, change addr/datatomem every cycle and keep read_req high for 10 cycles after mem_resp -> datafrommem constant and equal to data at the latched address; mem_resp drops exactly one edge after read_req falls.
- cs gating and back-to-back: requests with cs=0 -> no response. A new rd_v presented in the same cycle that read_req of the previous transaction falls -> accepted only on the posedge after mem_resp drops.
